zybo_sampler_top: RTL and testbench
===================================

ZYBO_SAMPLER_TOP -- requirements
Module: zybo_sampler_top

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, board clock frequency, informational only.
REQ-002 Parameter I2C_QDIV, default 125, board_clk cycles per SCL quarter-period, giving 100 kHz SCL.
REQ-003 Parameter INIT_DELAY, default 1_000_000, board_clk cycles from reset release to first I2C transaction.
REQ-004 Parameter CODEC_ADDR, default 7'h1A, codec I2C 7-bit address.
REQ-005 board_clk  in  1  single clock, 50 MHz; all logic in this domain.
REQ-006 reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-007 sw0  in  1  tone enable (1 = tone, 0 = zero samples).
REQ-008 sw1  in  1  loopback select (1 = playback sample = last captured ac_recdat sample).
REQ-009 sw2  in  1  unused, ignored.
REQ-010 sw3  in  1  force mute (1 = ac_muten low).
REQ-011 btn0  in  1  re-run codec init sequence on rising edge.
REQ-012 btn1, btn2, btn3  in  1 each  unused, ignored.
REQ-013 led0..led3  out  1 each  init_done, i2c_error, heartbeat, sw1 mirror.
REQ-014 ac_mclk, ac_bclk, ac_pblrc, ac_reclrc, ac_pbdat  out  1 each  codec master clock, bit clock, playback LR clock, record LR clock, playback data.
REQ-015 ac_muten  out  1  codec mute, active-low.
REQ-016 ac_recdat  in  1  codec record data.
REQ-017 i2c_scl  out  1  open-drain SCL: drives 0 or high-Z, never 1.
REQ-018 i2c_sda  inout  1  open-drain SDA via IOBUF primitive: T=1 releases (high-Z), T=0 drives I=0; O returns the pad value.

Function
REQ-019 Clock generation: ac_mclk = board_clk/4 (12.5 MHz, 50% duty); ac_bclk = board_clk/16; ac_pblrc = board_clk/1024 (64 bclk per frame, ~48.8 kHz); ac_reclrc identical to ac_pblrc.
REQ-020 I2S framing: ac_pblrc low = left, high = right; 24-bit sample, MSB first, MSB one bclk after each LRC edge; ac_pbdat changes on ac_bclk falling edge; bits beyond 24 per half-frame are 0.
REQ-021 Capture: ac_recdat sampled on ac_bclk rising edge with the same framing; left sample latched at end of left half.
REQ-022 Sample source: sw1=1 -> loopback captured sample (both channels); else sw0=1 -> square tone, +24'h200000 / -24'h200000 (24'hE00000), toggling every 32 frames (~763 Hz); else 24'h000000. Selection sampled once per frame at left-half start.
REQ-023 Init FSM states: WAIT (INIT_DELAY count), WRITE (one I2C register write), NEXT, DONE, ERROR.
REQ-024 Init table, in order, as {reg[6:0], data[8:0]}: R15=0x000, R6=0x010, R4=0x010, R5=0x000, R7=0x00A, R8=0x000, R9=0x001, R6=0x000.
REQ-025 Each write: START, byte 0x34 ({CODEC_ADDR,0}), byte {reg,data[8]}, byte data[7:0], STOP; MSB first; SDA changes only while SCL low; SCL high/low one half-period each (2 x I2C_QDIV).
REQ-026 ACK sampled in SCL-high middle of each 9th bit; SDA=1 (NACK) -> STOP issued, FSM to ERROR, led1=1, led0=0.
REQ-027 After 8th ACKed write -> DONE, led0=1; SCL and SDA released (high-Z) while idle.
REQ-028 btn0 rising edge, synchronized through 2 flops: from DONE or ERROR restarts at WRITE entry 0 and clears led1; ignored while a sequence is running.
REQ-029 ac_muten = init_done & ~sw3.
REQ-030 led2 toggles every 2^25 board_clk cycles; led3 = sw1.
REQ-031 All switch inputs are synchronized through 2 flops before use.

Reset
REQ-032 While reset=0: ac_mclk, ac_bclk, ac_pblrc, ac_pbdat = 0; ac_muten = 0; led0..led3 = 0; i2c_scl and i2c_sda high-Z; FSM = WAIT with counter cleared; tone = positive phase, frame counter 0.
REQ-033 Reset assertion mid-transaction aborts immediately with lines released; no STOP is generated.

Verification
REQ-034 Release reset with INIT_DELAY=100 and SDA held 0 (always ACK) -> 8 writes, first bytes 0x34,0x1E,0x00; led0=1 after 8th STOP; ac_muten=1 with sw3=0.
REQ-035 SDA released (pull-up, NACK) -> after first address byte STOP, led1=1, led0=0, ac_muten=0, no further START.
REQ-036 After REQ-035 condition, press btn0 with SDA held 0 -> led1 clears, full sequence completes, led0=1.
REQ-037 Measure clocks -> ac_mclk period 80 ns, ac_bclk period 320 ns, ac_pblrc period 20.48 us, ac_reclrc == ac_pblrc.
REQ-038 sw0=1, sw1=0 -> left word 0x200000 for 32 frames, then 0xE00000, MSB one bclk after LRC edge; sw0=0 -> 0x000000.
REQ-039 sw1=1, ac_recdat driving 0xABCDEF left -> following frames play 0xABCDEF on both channels; led3=1.

Source files
------------

// File: rtl/zybo_sampler_top.sv
`timescale 1ns/1ps
// Zybo audio sampler: codec clocks, I2S playback/capture, tone/loopback source
// selection and an I2C sequencer that programs the codec after reset.
module zybo_sampler_top #(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         I2C_QDIV   = 125,
  parameter int         INIT_DELAY = 1_000_000,
  parameter logic [6:0] CODEC_ADDR = 7'h1A
) (
  input  logic board_clk,
  input  logic reset,
  input  logic sw0,
  input  logic sw1,
  input  logic sw2,
  input  logic sw3,
  input  logic btn0,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic ac_mclk,
  output logic ac_bclk,
  output logic ac_pblrc,
  output logic ac_reclrc,
  output logic ac_pbdat,
  output logic ac_muten,
  input  logic ac_recdat,
  output logic i2c_scl,
  inout  wire  i2c_sda
);
  typedef enum logic [2:0] {S_WAIT, S_WRITE, S_NEXT, S_DONE, S_ERROR} state_t;
  localparam int         WW        = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam int         QW        = (I2C_QDIV > 1) ? $clog2(I2C_QDIV) : 1;
  localparam logic [4:0] SLOT_STOP = 5'd28;

  logic w_unused;
  assign w_unused = ^{sw2, btn1, btn2, btn3, CLK_HZ[0]};

  logic [1:0] r_sw0_s, r_sw1_s, r_sw3_s, r_btn_s, r_sda_s;
  logic       r_btn_d;
  logic       w_sw0, w_sw1, w_sw3, w_btn_rise;

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      r_sw0_s <= '0; r_sw1_s <= '0; r_sw3_s <= '0; r_btn_s <= '0;
      r_sda_s <= 2'b11; r_btn_d <= 1'b0;
    end else begin
      r_sw0_s <= {r_sw0_s[0], sw0};
      r_sw1_s <= {r_sw1_s[0], sw1};
      r_sw3_s <= {r_sw3_s[0], sw3};
      r_btn_s <= {r_btn_s[0], btn0};
      r_sda_s <= {r_sda_s[0], i2c_sda};
      r_btn_d <= r_btn_s[1];
    end
  end
  assign w_sw0      = r_sw0_s[1];
  assign w_sw1      = r_sw1_s[1];
  assign w_sw3      = r_sw3_s[1];
  assign w_btn_rise = r_btn_s[1] & ~r_btn_d;

  // r_div[1]=mclk, [3]=bclk, [8:4]=bit slot within half-frame, [9]=LRC
  logic [9:0]  r_div;
  logic [23:0] r_play, r_cap, r_rec_left, w_src;
  logic [4:0]  r_frame_cnt, w_nslot, w_bidx;
  logic        r_tone_neg, r_pbdat;

  assign w_nslot = r_div[8:4] + 5'd1;
  assign w_bidx  = 5'd24 - w_nslot;

  always_comb begin
    w_src = 24'h000000;
    if (w_sw1)      w_src = r_rec_left;
    else if (w_sw0) w_src = r_tone_neg ? 24'hE00000 : 24'h200000;
  end

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0; r_play <= '0; r_cap <= '0; r_rec_left <= '0;
      r_frame_cnt <= '0; r_tone_neg <= 1'b0; r_pbdat <= 1'b0;
    end else begin
      r_div <= r_div + 10'd1;
      // loaded on the cycle before bclk falls, for the slot that edge opens
      if (r_div[3:0] == 4'd15)
        r_pbdat <= (w_nslot >= 5'd1 && w_nslot <= 5'd24) ? r_play[w_bidx] : 1'b0;
      if (r_div[3:0] == 4'd7 && r_div[8:4] >= 5'd1 && r_div[8:4] <= 5'd24)
        r_cap <= {r_cap[22:0], ac_recdat};
      if (r_div == 10'd511) r_rec_left <= r_cap;
      if (r_div == 10'd1023) begin
        r_play      <= w_src;
        r_frame_cnt <= r_frame_cnt + 5'd1;
        if (r_frame_cnt == 5'd31) r_tone_neg <= ~r_tone_neg;
      end
    end
  end

  assign ac_mclk   = r_div[1];
  assign ac_bclk   = r_div[3];
  assign ac_pblrc  = r_div[9];
  assign ac_reclrc = r_div[9];
  assign ac_pbdat  = r_pbdat;

  logic [24:0] r_hb_cnt;
  logic        r_hb;
  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      r_hb_cnt <= '0; r_hb <= 1'b0;
    end else begin
      r_hb_cnt <= r_hb_cnt + 25'd1;
      if (&r_hb_cnt) r_hb <= ~r_hb;
    end
  end

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = {7'd15, 9'h000};
      3'd1:    init_word = {7'd6,  9'h010};
      3'd2:    init_word = {7'd4,  9'h010};
      3'd3:    init_word = {7'd5,  9'h000};
      3'd4:    init_word = {7'd7,  9'h00A};
      3'd5:    init_word = {7'd8,  9'h000};
      3'd6:    init_word = {7'd9,  9'h001};
      default: init_word = {7'd6,  9'h000};
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait;
  logic [QW-1:0] r_qdiv;
  logic [1:0]    r_q;
  logic [4:0]    r_slot, w_fidx;
  logic [2:0]    r_entry;
  logic          r_nack, r_scl_oe, r_sda_oe, w_scl_low, w_sda_low;
  logic          w_qtick, w_slot_end, w_ack_slot;
  logic [15:0]   w_tw;
  logic [26:0]   w_frame;

  // slot 0 = START, 1..27 = three bytes with their ACK bits, 28 = STOP
  assign w_tw       = init_word(r_entry);
  assign w_frame    = {CODEC_ADDR, 1'b0, 1'b1, w_tw[15:8], 1'b1, w_tw[7:0], 1'b1};
  assign w_fidx     = 5'd27 - r_slot;
  assign w_qtick    = (r_qdiv == QW'(I2C_QDIV - 1));
  assign w_slot_end = (r_state == S_WRITE) && w_qtick && (r_q == 2'd3);
  assign w_ack_slot = (r_slot == 5'd9) || (r_slot == 5'd18) || (r_slot == 5'd27);

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:          if (r_wait == WW'(INIT_DELAY - 1)) w_state_nxt = S_WRITE;
      S_WRITE:         if (w_slot_end && r_slot == SLOT_STOP)
                         w_state_nxt = r_nack ? S_ERROR : S_NEXT;
      S_NEXT:          w_state_nxt = (r_entry == 3'd7) ? S_DONE : S_WRITE;
      S_DONE, S_ERROR: if (w_btn_rise) w_state_nxt = S_WRITE;
      default:         w_state_nxt = S_WAIT;
    endcase
  end

  // SDA moves only in q0 while SCL is low; SCL is high in q1..q2 of data slots
  always_comb begin
    w_scl_low = 1'b0;
    w_sda_low = 1'b0;
    if (r_state == S_WRITE) begin
      if (r_slot == 5'd0) begin
        w_scl_low = (r_q == 2'd3);
        w_sda_low = (r_q >= 2'd2);
      end else if (r_slot >= SLOT_STOP) begin
        w_scl_low = (r_q == 2'd0);
        w_sda_low = (r_q != 2'd3);
      end else begin
        w_scl_low = (r_q == 2'd0) || (r_q == 2'd3);
        w_sda_low = ~w_frame[w_fidx];
      end
    end
  end

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0; r_qdiv <= '0; r_q <= '0; r_slot <= '0; r_entry <= '0;
      r_nack <= 1'b0; r_scl_oe <= 1'b0; r_sda_oe <= 1'b0;
    end else begin
      if (r_state == S_WAIT) r_wait <= r_wait + WW'(1);
      if (r_state != S_WRITE && w_state_nxt == S_WRITE) begin
        r_qdiv <= '0; r_q <= '0; r_slot <= '0; r_nack <= 1'b0;
      end else if (r_state == S_WRITE) begin
        r_qdiv <= w_qtick ? '0 : r_qdiv + QW'(1);
        if (w_qtick) r_q <= r_q + 2'd1;
        if (w_qtick && r_q == 2'd1 && w_ack_slot && r_sda_s[1]) r_nack <= 1'b1;
        if (w_slot_end) r_slot <= r_nack ? SLOT_STOP : r_slot + 5'd1;
      end
      if (r_state == S_NEXT && r_entry != 3'd7) r_entry <= r_entry + 3'd1;
      if ((r_state == S_DONE || r_state == S_ERROR) && w_btn_rise) r_entry <= '0;
      r_scl_oe <= w_scl_low;
      r_sda_oe <= w_sda_low;
    end
  end

  // open-drain pads; the SDA pair maps onto an IOBUF (T = ~r_sda_oe, I = 0)
  assign i2c_scl  = r_scl_oe ? 1'b0 : 1'bz;
  assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
  assign led0     = (r_state == S_DONE);
  assign led1     = (r_state == S_ERROR);
  assign led2     = r_hb;
  assign led3     = w_sw1;
  assign ac_muten = (r_state == S_DONE) & ~w_sw3;
endmodule

// File: tb/tb_zybo_sampler_top.sv
`timescale 1ns/1ps
// Directed bench: I2C init/NACK/retry, codec clock periods, I2S tone, silence and loopback.
module tb_zybo_sampler_top;
  logic board_clk = 1'b0, reset = 1'b0;
  logic sw0 = 1'b0, sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
  logic btn0 = 1'b0, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
  logic led0, led1, led2, led3;
  logic ac_mclk, ac_bclk, ac_pblrc, ac_reclrc, ac_pbdat, ac_muten;
  logic ac_recdat = 1'b0;
  wire  scl_w, sda_w;
  logic tb_sda_low = 1'b0, ack_en = 1'b1;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = tb_sda_low ? 1'b0 : 1'bz;

  always #10 board_clk = ~board_clk;

  zybo_sampler_top #(.I2C_QDIV(4), .INIT_DELAY(100)) dut (
    .board_clk(board_clk), .reset(reset),
    .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .btn0(btn0), .btn1(btn1), .btn2(btn2), .btn3(btn3),
    .led0(led0), .led1(led1), .led2(led2), .led3(led3),
    .ac_mclk(ac_mclk), .ac_bclk(ac_bclk), .ac_pblrc(ac_pblrc), .ac_reclrc(ac_reclrc),
    .ac_pbdat(ac_pbdat), .ac_muten(ac_muten), .ac_recdat(ac_recdat),
    .i2c_scl(scl_w), .i2c_sda(sda_w)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // I2C bus monitor plus an ACK-ing slave
  int n_start = 0, n_stop = 0, nb = 0, bitcnt = 0;
  logic [7:0] sh = '0;
  logic [7:0] bq [0:127];
  logic scl_q = 1'b1, sda_q = 1'b1;
  always @(scl_w or sda_w) begin
    if (scl_q && scl_w && sda_q && !sda_w) begin
      n_start++; bitcnt = 0;
    end else if (scl_q && scl_w && !sda_q && sda_w) begin
      n_stop++; bitcnt = 0;
    end else if (!scl_q && scl_w) begin
      bitcnt++;
      if (bitcnt <= 8) sh = {sh[6:0], sda_w};
      else begin
        if (nb < 128) bq[nb] = sh;
        nb++; bitcnt = 0;
      end
    end else if (scl_q && !scl_w) begin
      tb_sda_low = ack_en && (bitcnt == 8);
    end
    scl_q = scl_w; sda_q = sda_w;
  end

  // I2S playback decoder
  int slot_b = -1, nl = 0, nr = 0, pad_err = 0;
  logic lrc_q = 1'b0;
  logic [23:0] sh_b = '0;
  logic [23:0] lw [0:63];
  logic [23:0] rw [0:63];
  always @(posedge ac_bclk or negedge reset) begin
    if (!reset) begin
      slot_b = -1; lrc_q = 1'b0;
    end else begin
      if (ac_pblrc != lrc_q) slot_b = 0; else slot_b = slot_b + 1;
      lrc_q = ac_pblrc;
      if (slot_b >= 1 && slot_b <= 24) sh_b = {sh_b[22:0], ac_pbdat};
      else if (ac_pbdat) pad_err++;
      if (slot_b == 24) begin
        if (!ac_pblrc) begin if (nl < 64) lw[nl] = sh_b; nl++; end
        else begin if (nr < 64) rw[nr] = sh_b; nr++; end
      end
    end
  end

  // I2S record source: left 0xABCDEF, right 0x123456
  logic [23:0] rec_l = 24'hABCDEF, rec_r = 24'h123456, rec_w;
  int slot_r = 0;
  logic lrc_r = 1'b0;
  always @(negedge ac_bclk or negedge reset) begin
    if (!reset) begin
      slot_r = 0; lrc_r = 1'b0; ac_recdat = 1'b0;
    end else begin
      if (ac_pblrc != lrc_r) slot_r = 0; else slot_r = slot_r + 1;
      lrc_r = ac_pblrc;
      rec_w = ac_pblrc ? rec_r : rec_l;
      ac_recdat = (slot_r >= 1 && slot_r <= 24) ? rec_w[24 - slot_r] : 1'b0;
    end
  end

  task automatic press();
    btn0 = 1'b1;
    repeat (8) @(negedge board_clk);
    btn0 = 1'b0;
  endtask

  task automatic wait_led(input int which, input int budget, input string tag);
    logic hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge board_clk);
      hit = (which == 0) ? led0 : led1;
    end
    chk(tag, {31'd0, hit}, 1);
  endtask

  task automatic wait_words(input int target, input string tag);
    int i = 0;
    while (nl < target && i < 80000) begin @(negedge board_clk); i++; end
    chk(tag, {31'd0, nl >= target}, 1);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return ac_mclk;
      1:       return ac_bclk;
      default: return ac_pblrc;
    endcase
  endfunction

  task automatic measure(input int sel, output int per);
    logic prev, cur;
    realtime t0 = 0;
    int edges = 0;
    per = 0;
    prev = pick(sel);
    for (int i = 0; i < 3000 && edges < 2; i++) begin
      @(negedge board_clk);
      cur = pick(sel);
      if (cur && !prev) begin
        if (edges == 0) t0 = $realtime; else per = int'($realtime - t0);
        edges++;
      end
      prev = cur;
    end
  endtask

  initial begin
    int s0, p0, b0, k, per, mism, npos;
    sw0 = 1'b1;
    repeat (5) @(negedge board_clk);
    chk("rst_outs", {22'd0, ac_mclk, ac_bclk, ac_pblrc, ac_reclrc, ac_pbdat, ac_muten,
                     led0, led1, led2, led3}, 0);
    chk("rst_scl", {31'd0, scl_w}, 1);
    chk("rst_sda", {31'd0, sda_w}, 1);
    reset = 1'b1;

    wait_led(0, 10000, "init_done_timeout");
    chk("init_stops", n_stop, 8);
    chk("init_bytes", nb, 24);
    chk("byte0", bq[0], 8'h34);
    chk("byte1", bq[1], 8'h1E);
    chk("byte2", bq[2], 8'h00);
    chk("byte13_r7", bq[13], 8'h0E);
    chk("byte14_r7", bq[14], 8'h0A);
    chk("byte22_r6", bq[22], 8'h0C);
    chk("init_led1", {31'd0, led1}, 0);
    chk("init_muten", {31'd0, ac_muten}, 1);
    sw3 = 1'b1;
    repeat (4) @(negedge board_clk);
    chk("muten_sw3", {31'd0, ac_muten}, 0);
    sw3 = 1'b0;

    ack_en = 1'b0; s0 = n_start; p0 = n_stop; b0 = nb;
    press();
    wait_led(1, 5000, "nack_timeout");
    chk("nack_led0", {31'd0, led0}, 0);
    chk("nack_muten", {31'd0, ac_muten}, 0);
    chk("nack_bytes", nb - b0, 1);
    chk("nack_addr", bq[b0], 8'h34);
    chk("nack_stop", n_stop - p0, 1);
    repeat (500) @(negedge board_clk);
    chk("nack_no_restart", n_start - s0, 1);

    ack_en = 1'b1; p0 = n_stop;
    press();
    chk("retry_led1", {31'd0, led1}, 0);
    wait_led(0, 10000, "retry_timeout");
    chk("retry_stops", n_stop - p0, 8);
    chk("retry_led1_done", {31'd0, led1}, 0);

    measure(0, per); chk("mclk_ns", per, 80);
    measure(1, per); chk("bclk_ns", per, 320);
    measure(2, per); chk("pblrc_ns", per, 20480);
    mism = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge board_clk);
      if (ac_reclrc !== ac_pblrc) mism++;
    end
    chk("reclrc_eq", mism, 0);

    wait_words(34, "tone_timeout");
    chk("frame0_zero", lw[0], 24'h000000);
    npos = 0;
    for (int i = 1; i <= 32; i++) if (lw[i] == 24'h200000) npos++;
    chk("tone_pos_frames", npos, 32);
    chk("tone_neg", lw[33], 24'hE00000);

    sw0 = 1'b0; k = nl;
    wait_words(k + 3, "zero_timeout");
    chk("zero_left", lw[nl-1], 24'h000000);
    chk("zero_right", rw[nr-1], 24'h000000);

    sw1 = 1'b1; k = nl;
    wait_words(k + 4, "loop_timeout");
    chk("loop_left", lw[nl-1], 24'hABCDEF);
    chk("loop_right", rw[nr-1], 24'hABCDEF);
    chk("led3_sw1", {31'd0, led3}, 1);
    chk("pad_bits_zero", pad_err, 0);

    press();
    k = 0;
    while (scl_w !== 1'b0 && k < 2000) begin @(negedge board_clk); k++; end
    chk("abort_scl_low_seen", {31'd0, scl_w}, 0);
    repeat (3) @(negedge board_clk);
    reset = 1'b0;
    #1;
    chk("abort_scl", {31'd0, scl_w}, 1);
    chk("abort_sda", {31'd0, sda_w}, 1);
    chk("abort_outs", {26'd0, ac_mclk, ac_bclk, ac_pblrc, ac_pbdat, ac_muten, led0}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
